// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared declarations for the layer-level blocks of the fully-connected
// network datapath.
//   ser_state_t  : serializer FSM states (IDLE, SHIFT)
//   DATA_WIDTH   : default neuron sample width
//   idx_width()  : width needed to index n items (never less than 1 bit)
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DATA_WIDTH = 16;

    // $clog2 wrapper; a single-item index still needs one bit so that port
    // and counter declarations never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// -----------------------------------------------------------------------------
// argmax_tracker
// Watches a serial sample stream and reports, after each frame, the index of
// the largest signed sample in that frame. On ties the earlier index is kept.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   valid        : sample present this cycle
//   data         : sample value (two's complement)
//   first        : sample is index 0 of its frame
//   last         : sample is the final one of its frame
//   class_valid  : one-cycle pulse, the cycle after the last sample
//   class_idx    : winning index of the most recent frame (held between frames)
// -----------------------------------------------------------------------------
module argmax_tracker
    import nn_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic [dataWidth-1:0]      data,
    input  logic                      first,
    input  logic                      last,
    output logic                      class_valid,
    output logic [idx_width(NN)-1:0]  class_idx
);

    localparam int CW = idx_width(NN);

    logic [dataWidth-1:0] max_reg;
    logic [CW-1:0]        idx_reg;
    logic [CW-1:0]        pos_reg;
    logic                 class_valid_reg;
    logic [CW-1:0]        class_idx_reg;

    logic [CW-1:0]        cur_idx;
    logic                 take;
    logic [CW-1:0]        best_idx_next;

    // The position counter is re-based on every first sample so a frame
    // never inherits an index from the previous one.
    always_comb begin
        cur_idx       = first ? '0 : pos_reg;
        // Strict greater-than keeps the lower index on ties.
        take          = first || ($signed(data) > $signed(max_reg));
        best_idx_next = take ? cur_idx : idx_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_reg         <= '0;
            idx_reg         <= '0;
            pos_reg         <= '0;
            class_valid_reg <= 1'b0;
            class_idx_reg   <= '0;
        end else begin
            class_valid_reg <= valid && last;
            if (valid) begin
                pos_reg <= cur_idx + CW'(1);
                if (take) begin
                    max_reg <= data;
                    idx_reg <= cur_idx;
                end
                // The last sample itself takes part in the comparison, so
                // publish the combinational winner rather than idx_reg.
                if (last) begin
                    class_idx_reg <= best_idx_next;
                end
            end
        end
    end

    assign class_valid = class_valid_reg;
    assign class_idx   = class_idx_reg;

endmodule

// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
// Captures the parallel outputs of a fully-connected layer and replays them
// one sample per cycle as the serial x_valid/x_in feed of the next layer.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_valid[NN]    : per-neuron valid; neurons fire in lockstep, only bit 0
//                    is used as the capture trigger
//   i_data         : packed neuron outputs, neuron k at [k*dataWidth +: dataWidth]
//   o_valid        : serial sample valid
//   o_data         : serial sample (bit-exact copy of the captured value)
//   o_last         : final sample of the frame (index NN-1)
//   busy           : frame being shifted out
//   overrun        : sticky; a frame arrived mid-shift and was dropped
//
// Optional (LAYER_SERIALIZER_ARGMAX_EN defined):
//   o_class_valid  : pulses the cycle after o_last
//   o_class        : index of the largest signed sample of that frame
//
// Timing: a trigger sampled at edge T puts sample 0 on the outputs so that
// it is presented at edge T+1; sample NN-1 (with o_last) is presented at edge
// T+NN. Outputs are decoded directly from registers. A trigger sampled at
// the edge that consumes the last sample reloads the frame with no bubble.
// -----------------------------------------------------------------------------
module layer_serializer
    import nn_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             i_valid,
    input  logic [NN*dataWidth-1:0]   i_data,
    output logic                      o_valid,
    output logic [dataWidth-1:0]      o_data,
    output logic                      o_last,
    output logic                      busy,
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    output logic                      overrun,
    output logic                      o_class_valid,
    output logic [idx_width(NN)-1:0]  o_class
`else
    output logic                      overrun
`endif
);

    localparam int CW = idx_width(NN);

    ser_state_t           state_reg, state_next;
    logic [CW-1:0]        count_reg, count_next;
    logic                 overrun_reg, overrun_next;
    logic                 load;
    logic                 shift;
    logic                 trigger;
    logic                 at_last;

    // Hold shift register: slot 0 is always the sample being presented.
    logic [dataWidth-1:0] hold_reg [NN];

    assign trigger = i_valid[0];
    assign at_last = (state_reg == SHIFT) && (count_reg == CW'(NN - 1));

    // The lockstep valids beyond bit 0 carry no extra information.
    logic unused_valid_bits;
    assign unused_valid_bits = ^i_valid[NN-1:1];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            overrun_reg <= overrun_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        overrun_next = overrun_reg;
        load         = 1'b0;
        shift        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (trigger) begin
                    load       = 1'b1;
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (at_last) begin
                    // Count stops at NN-1 and returns to 0 either way.
                    count_next = '0;
                    if (trigger) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    count_next = count_reg + CW'(1);
                    // Mid-frame arrival is dropped; current frame continues.
                    if (trigger) begin
                        overrun_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hold shift register, one slot per neuron. Load takes priority over
    // shift so a back-to-back capture replaces the drained frame.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_hold
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg[gi] <= '0;
                end else if (load) begin
                    hold_reg[gi] <= i_data[gi*dataWidth +: dataWidth];
                end else if (shift) begin
                    if (gi == NN - 1) begin
                        hold_reg[gi] <= '0;
                    end else begin
                        hold_reg[gi] <= hold_reg[(gi == NN - 1) ? gi : gi + 1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_valid = (state_reg == SHIFT);
    assign o_data  = hold_reg[0];
    assign o_last  = at_last;
    assign busy    = (state_reg == SHIFT);
    assign overrun = overrun_reg;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    logic first_sample;
    assign first_sample = (state_reg == SHIFT) && (count_reg == '0);

    argmax_tracker #(
        .NN        (NN),
        .dataWidth (dataWidth)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .valid       (o_valid),
        .data        (o_data),
        .first       (first_sample),
        .last        (o_last),
        .class_valid (o_class_valid),
        .class_idx   (o_class)
    );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// -----------------------------------------------------------------------------
// tb_layer_serializer
// Self-checking bench for layer_serializer (NN=10, dataWidth=16).
// A queue model holds the samples still to be presented; a compare process
// checks every output each cycle, and the stimulus flow adds hand-computed
// literal checks at the key cycles.
// -----------------------------------------------------------------------------
module tb_layer_serializer;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int CW = $clog2(NN);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NN-1:0]     i_valid = '0;
    logic [NN*DW-1:0]  i_data = '0;
    logic              o_valid;
    logic [DW-1:0]     o_data;
    logic              o_last;
    logic              busy;
    logic              overrun;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    logic              o_class_valid;
    logic [CW-1:0]     o_class;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .busy          (busy),
`ifdef LAYER_SERIALIZER_ARGMAX_EN
        .overrun       (overrun),
        .o_class_valid (o_class_valid),
        .o_class       (o_class)
`else
        .overrun       (overrun)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [DW-1:0] d;
        bit            last;
        int            cls;
    } samp_t;

    samp_t q[$];
    samp_t h;
    bit    m_over  = 0;
    bit    m_cv    = 0;
    int    m_class = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_over  = 0;
            m_cv    = 0;
            m_class = 0;
        end else begin
            m_cv = 0;
            if (q.size() > 0) begin
                h = q.pop_front();
                if (h.last) begin
                    m_cv    = 1;
                    m_class = h.cls;
                end
            end
            if (i_valid[0]) begin
                if (q.size() == 0) begin
                    int best;
                    best = 0;
                    for (int i = 1; i < NN; i++)
                        if ($signed(i_data[i*DW +: DW]) > $signed(i_data[best*DW +: DW]))
                            best = i;
                    for (int i = 0; i < NN; i++) begin
                        samp_t s;
                        s.d    = i_data[i*DW +: DW];
                        s.last = (i == NN - 1);
                        s.cls  = best;
                        q.push_back(s);
                    end
                end else begin
                    m_over = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("o_valid", 32'(o_valid), 32'(q.size() > 0));
            check("busy", 32'(busy), 32'(q.size() > 0));
            check("overrun", 32'(overrun), 32'(m_over));
            check("o_last", 32'(o_last), (q.size() > 0) ? 32'(q[0].last) : 32'd0);
            if (q.size() > 0)
                check("o_data", 32'(o_data), 32'(q[0].d));
`ifdef LAYER_SERIALIZER_ARGMAX_EN
            check("o_class_valid", 32'(o_class_valid), 32'(m_cv));
            check("o_class", 32'(o_class), 32'(m_class));
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] fr [NN];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present frame fr for exactly one edge, then drop the valid.
    task automatic fire();
        for (int i = 0; i < NN; i++) i_data[i*DW +: DW] = fr[i];
        i_valid = '1;
        tick();
        i_valid = '0;
    endtask

    initial begin
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_o_last", 32'(o_last), 32'd0);
        check("reset_o_data", 32'(o_data), 32'd0);
        tick();

        // Single frame 1..10
        for (int i = 0; i < NN; i++) fr[i] = DW'(i + 1);
        fire();
        check("single_first_data", 32'(o_data), 32'd1);
        for (int k = 1; k < NN; k++) begin
            tick();
            check("single_data", 32'(o_data), 32'(k + 1));
            check("single_last", 32'(o_last), 32'(k == NN - 1));
        end
        tick();
        check("single_valid_end", 32'(o_valid), 32'd0);
        check("single_busy_end", 32'(busy), 32'd0);
        repeat (3) tick();

        // Back-to-back: second trigger on the o_last cycle
        for (int i = 0; i < NN; i++) fr[i] = DW'(16'h0100 + i);
        fire();
        for (int k = 1; k < NN; k++) tick();
        check("b2b_last_before_reload", 32'(o_last), 32'd1);
        for (int i = 0; i < NN; i++) fr[i] = DW'(16'h0200 + i);
        fire();
        check("b2b_second_first", 32'(o_data), 32'h200);
        check("b2b_no_gap", 32'(o_valid), 32'd1);
        for (int k = 1; k < NN; k++) tick();
        check("b2b_second_last", 32'(o_data), 32'h209);
        tick();
        check("b2b_overrun", 32'(overrun), 32'd0);
        repeat (2) tick();

        // Overrun: second trigger at T+4
        for (int i = 0; i < NN; i++) fr[i] = DW'(16'h0A00 + i);
        fire();
        for (int k = 1; k < 4; k++) tick();
        for (int i = 0; i < NN; i++) fr[i] = DW'(16'h0B00 + i);
        fire();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_frame_intact", 32'(o_data), 32'h0A04);
        repeat (10) tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_dropped_idle", 32'(o_valid), 32'd0);

        // Reset mid-frame at T+5
        for (int i = 0; i < NN; i++) fr[i] = DW'(16'h0C00 + i);
        fire();
        for (int k = 1; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        tick();
        for (int i = 0; i < NN; i++) fr[i] = DW'(16'h0D00 + i);
        fire();
        check("post_rst_first", 32'(o_data), 32'h0D00);
        repeat (12) tick();

`ifdef LAYER_SERIALIZER_ARGMAX_EN
        // Argmax with a tie on 0x7FFF at indices 2 and 4
        fr[0] = 16'hFFFD; fr[1] = 16'h0007; fr[2] = 16'h7FFF; fr[3] = 16'h0002;
        fr[4] = 16'h7FFF; fr[5] = 16'h8000; fr[6] = 16'h0000; fr[7] = 16'h0001;
        fr[8] = 16'h0005; fr[9] = 16'h0009;
        fire();
        for (int k = 1; k < NN; k++) tick();
        tick();
        check("argmax_cv", 32'(o_class_valid), 32'd1);
        check("argmax_tie_class", 32'(o_class), 32'd2);
        tick();
        check("argmax_cv_pulse", 32'(o_class_valid), 32'd0);
        // All-negative frame: -8 at index 7 is the least negative
        fr[0] = 16'hFF9C; fr[1] = 16'hFFCE; fr[2] = 16'hFFE2; fr[3] = 16'hFFBA;
        fr[4] = 16'hFFF7; fr[5] = 16'hFF38; fr[6] = 16'hFC18; fr[7] = 16'hFFF8;
        fr[8] = 16'hFFF7; fr[9] = 16'h8000;
        fire();
        for (int k = 1; k < NN; k++) tick();
        tick();
        check("argmax_neg_cv", 32'(o_class_valid), 32'd1);
        check("argmax_neg_class", 32'(o_class), 32'd7);
        repeat (4) tick();
        check("argmax_hold", 32'(o_class), 32'd7);
`endif

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
